// File: rtl/rc4_pkg.sv
// Shared types and plaintext alphabet for the RC4 brute-force key search.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_W_INIT,
        ST_KSA,
        ST_W_KSA,
        ST_DEC,
        ST_W_DEC,
        ST_NEXT,
        ST_FOUND,
        ST_FAIL
    } search_state_t;

    localparam logic [7:0] PLAIN_LO    = 8'h61;
    localparam logic [7:0] PLAIN_HI    = 8'h7A;
    localparam logic [7:0] PLAIN_SPACE = 8'h20;

    function automatic logic is_plain(input logic [7:0] b);
        return ((b >= PLAIN_LO) && (b <= PLAIN_HI)) || (b == PLAIN_SPACE);
    endfunction

endpackage

// File: rtl/rc4_plaintext_checker.sv
// Counts decrypted bytes for one candidate and remembers whether any fell
// outside the plaintext alphabet.
module rc4_plaintext_checker
    import rc4_pkg::*;
#(
    parameter int MESSAGE_LENGTH = 32,
    parameter int COUNT_W        = $clog2(MESSAGE_LENGTH + 2)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wren,
    input  logic [7:0]         data,
    output logic               bad,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
            bad   <= 1'b0;
        end else if (wren) begin
            // Saturate so an over-long message can never wrap back onto a match.
            if (count != '1) begin
                count <= count + 1'b1;
            end
            if (!is_plain(data)) begin
                bad <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force key search: walks candidate keys through S-init, key schedule
// and decrypt, stopping at the first key whose message is all plaintext.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_INIT   | init_start pulse high
// ST_W_INIT | waiting for init_finish
// ST_KSA    | ksa_start pulse high
// ST_W_KSA  | waiting for ksa_finish
// ST_DEC    | dec_start pulse high, plaintext checker cleared
// ST_W_DEC  | screening decrypted bytes, waiting for dec_finish
// ST_NEXT   | candidate rejected; advance key or give up
// ST_FOUND  | secret_key holds the match
// ST_FAIL   | range exhausted
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                  KEY_BITS       = 22,
    parameter logic [KEY_BITS-1:0] KEY_FIRST      = '0,
    parameter logic [KEY_BITS-1:0] KEY_LAST       = '1,
    parameter int                  MESSAGE_LENGTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        init_start,
    input  logic        init_finish,
    output logic        ksa_start,
    input  logic        ksa_finish,
    output logic        dec_start,
    input  logic        dec_finish,
    output logic        dec_abort,
    input  logic        dec_wren,
    input  logic [7:0]  dec_data,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        found,
    output logic        failed
);

    localparam int COUNT_W = $clog2(MESSAGE_LENGTH + 2);

    search_state_t       state;
    logic [KEY_BITS-1:0] key;
    logic [COUNT_W-1:0]  byte_count;
    logic                bad_seen;
    logic                bad_byte;
    logic [COUNT_W:0]    count_now;
    logic                msg_ok;

    rc4_plaintext_checker #(
        .MESSAGE_LENGTH (MESSAGE_LENGTH),
        .COUNT_W        (COUNT_W)
    ) u_checker (
        .clock (clock),
        .reset (reset),
        .clear (dec_start),
        .wren  (dec_wren),
        .data  (dec_data),
        .bad   (bad_seen),
        .count (byte_count)
    );

    // A byte written in the same cycle as dec_finish still has to be judged.
    assign bad_byte  = dec_wren && !is_plain(dec_data);
    assign count_now = {1'b0, byte_count} + (COUNT_W + 1)'(dec_wren);
    assign msg_ok    = !bad_seen && !bad_byte &&
                       (count_now == (COUNT_W + 1)'(MESSAGE_LENGTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            key        <= KEY_FIRST;
            secret_key <= '0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            dec_abort  <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            failed     <= 1'b0;
        end else begin
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            case (state)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (start) begin
                        state      <= ST_INIT;
                        key        <= KEY_FIRST;
                        secret_key <= 24'(KEY_FIRST);
                        found      <= 1'b0;
                        failed     <= 1'b0;
                        busy       <= 1'b1;
                        init_start <= 1'b1;
                    end
                end
                ST_INIT: state <= ST_W_INIT;
                ST_W_INIT: begin
                    if (init_finish) begin
                        state     <= ST_KSA;
                        ksa_start <= 1'b1;
                    end
                end
                ST_KSA: state <= ST_W_KSA;
                ST_W_KSA: begin
                    if (ksa_finish) begin
                        state     <= ST_DEC;
                        dec_start <= 1'b1;
                    end
                end
                ST_DEC: state <= ST_W_DEC;
                ST_W_DEC: begin
                    if (dec_finish) begin
                        dec_abort <= 1'b0;
                        if (msg_ok) begin
                            state <= ST_FOUND;
                            found <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end else if (bad_byte) begin
                        dec_abort <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (key == KEY_LAST) begin
                        state  <= ST_FAIL;
                        failed <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        key        <= key + 1'b1;
                        secret_key <= 24'(key + 1'b1);
                        state      <= ST_INIT;
                        init_start <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl over keys 0..3 with stub task FSMs.
module tb_rc4_key_search_ctrl;

    localparam int M_FIND  = 0;
    localparam int M_BAD   = 1;
    localparam int M_COINC = 2;
    localparam int M_SHORT = 3;

    logic        clock;
    logic        reset;
    logic        start;
    logic        init_start, ksa_start, dec_start, dec_abort;
    logic        init_finish, ksa_finish, dec_finish;
    logic        dec_wren;
    logic [7:0]  dec_data;
    logic [23:0] secret_key;
    logic        busy, found, failed;

    logic si_fin, sk_fin, sd_fin, sd_wren;
    logic mi_fin, mk_fin, md_fin;
    logic [7:0] sd_data;

    assign init_finish = si_fin | mi_fin;
    assign ksa_finish  = sk_fin | mk_fin;
    assign dec_finish  = sd_fin | md_fin;
    assign dec_wren    = sd_wren;
    assign dec_data    = sd_data;

    int n_chk = 0;
    int n_fail = 0;
    int stub_en = 0;
    int mode = M_FIND;
    int abort_checked = 0;
    int n_init = 0;
    int both_cnt = 0;
    logic [23:0] init_key_log [0:63];

    rc4_key_search_ctrl #(
        .KEY_BITS       (22),
        .KEY_FIRST      (22'd0),
        .KEY_LAST       (22'd3),
        .MESSAGE_LENGTH (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .init_start  (init_start),
        .init_finish (init_finish),
        .ksa_start   (ksa_start),
        .ksa_finish  (ksa_finish),
        .dec_start   (dec_start),
        .dec_finish  (dec_finish),
        .dec_abort   (dec_abort),
        .dec_wren    (dec_wren),
        .dec_data    (dec_data),
        .secret_key  (secret_key),
        .busy        (busy),
        .found       (found),
        .failed      (failed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic legal(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic int msg_len(input logic [7:0] k);
        case (mode)
            M_FIND:  return (k == 8'd2) ? 32 : 1;
            M_BAD:   return 1;
            M_SHORT: return 31;
            default: return 32;
        endcase
    endfunction

    function automatic logic [7:0] msg_byte(input logic [7:0] k, input int i);
        logic [7:0] b;
        if (mode == M_BAD || (mode == M_FIND && k != 8'd2)) return 8'h41;
        if (mode == M_COINC && i == 31) return 8'h7B;
        b = 8'h61 + 8'(i % 26);
        if (i % 8 == 7) b = 8'h20;
        return b;
    endfunction

    always @(negedge clock) begin
        if (init_start) begin
            init_key_log[n_init[5:0]] <= secret_key;
            n_init <= n_init + 1;
        end
        if (found && failed) both_cnt <= both_cnt + 1;
    end

    initial begin : init_stub
        si_fin = 1'b0;
        forever begin
            @(negedge clock);
            if (init_start && stub_en != 0) begin
                repeat (2) @(posedge clock);
                #1 si_fin = 1'b1;
                @(posedge clock);
                #1 si_fin = 1'b0;
            end
        end
    end

    initial begin : ksa_stub
        sk_fin = 1'b0;
        forever begin
            @(negedge clock);
            if (ksa_start && stub_en != 0) begin
                repeat (2) @(posedge clock);
                #1 sk_fin = 1'b1;
                @(posedge clock);
                #1 sk_fin = 1'b0;
            end
        end
    end

    task automatic run_dec(input logic [7:0] k);
        int n;
        logic stop;
        logic [7:0] b;
        n = msg_len(k);
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            @(posedge clock);
            #1;
            b = msg_byte(k, i);
            sd_wren = 1'b1;
            sd_data = b;
            sd_fin  = (mode == M_COINC) && (i == n - 1);
            @(negedge clock);
            if (!sd_fin && !legal(b)) begin
                if (abort_checked == 0) check("dec_abort_same_cycle", dec_abort, 1'b0);
                @(posedge clock);
                #1 sd_wren = 1'b0;
                @(negedge clock);
                if (abort_checked == 0) check("dec_abort_next_cycle", dec_abort, 1'b1);
                abort_checked = 1;
                stop = 1'b1;
            end
        end
        if (sd_fin) begin
            @(posedge clock);
            #1 sd_wren = 1'b0;
            sd_fin = 1'b0;
        end else begin
            @(posedge clock);
            #1 sd_wren = 1'b0;
            sd_fin = 1'b1;
            @(posedge clock);
            #1 sd_fin = 1'b0;
        end
    endtask

    initial begin : dec_stub
        sd_wren = 1'b0;
        sd_data = 8'h00;
        sd_fin  = 1'b0;
        forever begin
            @(negedge clock);
            if (dec_start && stub_en != 0) run_dec(secret_key[7:0]);
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic pulse_man(input int which);
        @(posedge clock);
        #1;
        if (which == 0) mi_fin = 1'b1;
        if (which == 1) mk_fin = 1'b1;
        if (which == 2) md_fin = 1'b1;
        @(posedge clock);
        #1;
        mi_fin = 1'b0;
        mk_fin = 1'b0;
        md_fin = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (!(found || failed) && i < budget) begin
            @(negedge clock);
            i++;
        end
        check(tag, 32'(i < budget), 1);
    endtask

    initial begin : main
        int n0;
        reset = 1'b1;
        start = 1'b0;
        mi_fin = 1'b0;
        mk_fin = 1'b0;
        md_fin = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_found", found, 0);
        check("rst_failed", failed, 0);
        check("rst_key", secret_key, 0);
        check("rst_init_start", init_start, 0);
        check("rst_dec_abort", dec_abort, 0);

        // Manual handshakes: spurious inputs in W_INIT, turnaround, reset in W_KSA.
        pulse_start();
        @(negedge clock);
        check("start_to_init_start", init_start, 1);
        check("busy_in_init", busy, 1);
        @(negedge clock);
        check("init_start_one_cycle", init_start, 0);
        @(posedge clock);
        #1 start = 1'b1; mk_fin = 1'b1; md_fin = 1'b1;
        @(posedge clock);
        #1 start = 1'b0; mk_fin = 1'b0; md_fin = 1'b0;
        @(negedge clock);
        check("spurious_no_ksa_start", ksa_start, 0);
        check("spurious_no_init_start", init_start, 0);
        check("spurious_key", secret_key, 0);
        pulse_man(0);
        @(negedge clock);
        check("init_fin_to_ksa_start", ksa_start, 1);
        pulse_man(1);
        @(negedge clock);
        check("ksa_fin_to_dec_start", dec_start, 1);
        pulse_man(2);
        @(negedge clock);
        check("empty_msg_not_found", found, 0);
        check("next_no_init_start", init_start, 0);
        @(negedge clock);
        check("turnaround_init_start", init_start, 1);
        check("turnaround_key", secret_key, 1);
        pulse_man(0);
        pulse_man(1);
        pulse_man(2);
        @(negedge clock);
        @(negedge clock);
        check("key2_init_start", init_start, 1);
        pulse_man(0);
        @(negedge clock);
        @(negedge clock);
        check("w_ksa_key", secret_key, 2);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_found", found, 0);
        check("midrst_failed", failed, 0);
        check("midrst_key", secret_key, 0);
        repeat (2) @(negedge clock);
        check("midrst_stays_idle", init_start, 0);

        // Key 2 is the only legal message.
        stub_en = 1;
        mode = M_FIND;
        n0 = n_init;
        pulse_start();
        wait_done("find_timeout", 3000);
        @(negedge clock);
        check("find_found", found, 1);
        check("find_failed", failed, 0);
        check("find_key", secret_key, 24'h000002);
        check("find_busy", busy, 0);
        check("find_init_pulses", n_init - n0, 3);
        check("find_log_key2", init_key_log[6'(n0 + 2)], 2);

        // Every key emits 'A' first: exhaust the range.
        mode = M_BAD;
        n0 = n_init;
        pulse_start();
        @(negedge clock);
        check("restart_clears_found", found, 0);
        wait_done("bad_timeout", 3000);
        @(negedge clock);
        check("bad_failed", failed, 1);
        check("bad_found", found, 0);
        check("bad_last_key", secret_key, 3);
        check("bad_init_pulses", n_init - n0, 4);

        // Illegal final byte lands with dec_finish.
        mode = M_COINC;
        n0 = n_init;
        pulse_start();
        wait_done("coinc_timeout", 5000);
        @(negedge clock);
        check("coinc_found", found, 0);
        check("coinc_failed", failed, 1);
        check("coinc_init_pulses", n_init - n0, 4);
        check("coinc_second_key", init_key_log[6'(n0 + 1)], 1);

        // 31 legal bytes is a short message.
        mode = M_SHORT;
        n0 = n_init;
        pulse_start();
        wait_done("short_timeout", 5000);
        @(negedge clock);
        check("short_found", found, 0);
        check("short_failed", failed, 1);
        check("short_init_pulses", n_init - n0, 4);
        stub_en = 0;
        pulse_start();
        @(negedge clock);
        check("rearm_failed_clr", failed, 0);
        check("rearm_found_clr", found, 0);
        check("rearm_key_first", secret_key, 0);
        check("rearm_init_start", init_start, 1);
        check("rearm_busy", busy, 1);
        check("never_both_flags", both_cnt, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Brute-force key search controller for the RC4 decryption datapath. Per candidate key it sequences the three task FSMs: S-init, key schedule, then decrypt. It checks every decrypted byte against the plaintext alphabet and aborts a candidate at the first illegal byte. It replaces the fixed-key controller at the top level and drives `secret_key` from an internal counter instead of the switches.

## Interface
- `KEY_BITS`, default 22: searched key width; the 24-bit key is `{2'b0, counter}`.
- `KEY_FIRST`, default 0: first candidate.
- `KEY_LAST`, default 2^22-1: last candidate, inclusive.
- `MESSAGE_LENGTH`, default 32: decrypted bytes per candidate.
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a search.
- `init_start` out 1: one-cycle pulse to the S-init FSM.
- `init_finish` in 1: one-cycle done pulse from S-init.
- `ksa_start` out 1: pulse to the key-schedule FSM.
- `ksa_finish` in 1: done pulse from the key-schedule FSM.
- `dec_start` out 1: pulse to the decrypt FSM.
- `dec_finish` in 1: done pulse from the decrypt FSM.
- `dec_abort` out 1: level; the decrypt FSM must return to idle and pulse `dec_finish` within 4 cycles.
- `dec_wren` in 1: decrypt-RAM write strobe.
- `dec_data` in 8: byte being written.
- `secret_key` out 24: current candidate, stable from `init_start` through `dec_finish`.
- `busy` out 1: search in progress.
- `found` out 1: sticky; `secret_key` holds the match.
- `failed` out 1: sticky; range exhausted.

## Operation
- States:
  - IDLE
  - INIT, W_INIT
  - KSA, W_KSA
  - DEC, W_DEC
  - NEXT
  - FOUND
  - FAIL
- Reset values: state=IDLE, all outputs 0, key counter=KEY_FIRST, byte count=0, bad flag=0.
- IDLE + `start`: go to INIT; clear `found`/`failed`; load key=KEY_FIRST.
- INIT → W_INIT: pulses `init_start`. W_INIT holds until `init_finish`, then KSA.
- KSA → W_KSA: same pattern with `ksa_start`/`ksa_finish`.
- DEC → W_DEC: pulses `dec_start`; clears byte count and bad flag.
- In W_DEC, on each `dec_wren`:
  - count increments.
  - A legal byte is 8'h61–8'h7A ('a'–'z') or 8'h20 (space).
  - Any other byte sets the bad flag and raises `dec_abort`. `dec_abort` holds until `dec_finish`.
- W_DEC + `dec_finish`:
  - not bad and count==MESSAGE_LENGTH → FOUND.
  - otherwise → NEXT.
- NEXT:
  - key==KEY_LAST → FAIL, with no wrap.
  - else key+1 → INIT.
- FOUND and FAIL: `busy`=0; the flag holds. `start` re-arms the search from KEY_FIRST.
- `busy`=1 in every state except IDLE/FOUND/FAIL.
- The S memory is re-initialised for every candidate. No state carries between keys.

## Timing
- `start` → `init_start` is 1 cycle. Each `*_finish` → next `*_start` is 1 cycle.
- Bad byte on `dec_wren` at cycle t → `dec_abort`=1 at t+1.
- Candidate turnaround: `dec_finish` → next `init_start` is 2 cycles (NEXT, INIT).
- `start` while busy: ignored.
- `*_finish` in a state other than its W_ state: ignored.
- `dec_wren` with a bad byte in the same cycle as `dec_finish`: the byte is checked, and the candidate fails.
- `dec_finish` with count<MESSAGE_LENGTH and no bad byte: the candidate fails (short message).
- KEY_FIRST==KEY_LAST: exactly one candidate is tried.
- `reset` mid-search: next cycle IDLE with all outputs at reset values. Sub-FSMs share `reset` and return to idle themselves.
- `found` and `failed` are never 1 together.

## Structure
- Package `rc4_pkg` holds:
  - the `search_state_t` enum;
  - `PLAIN_LO`=8'h61, `PLAIN_HI`=8'h7A, `PLAIN_SPACE`=8'h20;
  - function `is_plain(byte)`.
- Sub-module `rc4_plaintext_checker` holds the byte counter and sticky bad flag. Inputs: `clock`, `reset`, `clear`, `wren`, `data`. Outputs: `bad`, `count`.
- The top-level module holds the FSM and the key counter.

## Test plan
- Reset mid-W_KSA with key=5 → next cycle IDLE; `busy`/`found`/`failed`=0; `secret_key`=0.
- KEY_FIRST=0, KEY_LAST=3, stub decrypt model where only key 2 emits 32 legal bytes → `found`=1, `secret_key`=24'h000002, 3 `init_start` pulses total.
- KEY_FIRST=0, KEY_LAST=1, both keys emit byte 8'h41 at index 0 → `dec_abort` 1 cycle after the write, then `failed`=1, `found`=0.
- Bad byte 8'h7B coincident with `dec_finish`, key 0 → NEXT, then key 1 INIT.
- `start` pulsed during W_INIT, and spurious `ksa_finish` in W_INIT → no state change; `secret_key` unchanged.
- Legal message of only 31 bytes, then `dec_finish` → candidate rejected; after FAIL a new `start` restarts at KEY_FIRST with flags cleared.
